// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter unit.
// Holds the next-PC mode constants and the control FSM state type.
package pc_pkg;

   localparam logic [2:0] SEQ    = 3'd0;
   localparam logic [2:0] BRANCH = 3'd1;
   localparam logic [2:0] JUMP   = 3'd2;
   localparam logic [2:0] CALL   = 3'd3;
   localparam logic [2:0] RET    = 3'd4;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FAULT = 2'd2
   } pc_state_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: LIFO with one push or one pop per cycle.
// Illegal requests (push when full, pop when empty, or both together) are flagged and ignored.
module pc_ras
   import pc_pkg::*;
#(
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned RAS_DEPTH = 8,
   localparam int unsigned CNT_W    = $clog2(RAS_DEPTH + 1)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] top_data_o,
   output logic              full_o,
   output logic              empty_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              err_o
);

   localparam int unsigned IDX_W = $clog2(RAS_DEPTH);

   logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
   logic [CNT_W-1:0]  count_q, count_d;
   logic [IDX_W-1:0]  top_idx, push_idx;
   logic              do_push, do_pop;

   assign full_o   = (count_q == CNT_W'(RAS_DEPTH));
   assign empty_o  = (count_q == '0);
   assign count_o  = count_q;

   assign push_idx   = IDX_W'(count_q);
   assign top_idx    = IDX_W'(count_q - CNT_W'(1));
   assign top_data_o = mem_q[top_idx];

   assign do_push = push_i & ~pop_i & ~full_o;
   assign do_pop  = pop_i & ~push_i & ~empty_o;
   assign err_o   = (push_i & pop_i) | (push_i & full_o) | (pop_i & empty_o);

   always_comb begin
      count_d = count_q;
      if (do_push) begin
         count_d = count_q + CNT_W'(1);
      end else if (do_pop) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the count alone decides which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         mem_q[push_idx] <= push_data_i;
      end
   end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: next-PC selection, boot/run/fault control and a return-address stack.
// Instrucao comes straight from a register, so every mode change takes effect one edge later.
module pc_unit
   import pc_pkg::*;
#(
   parameter int unsigned       ADDR_W       = 11,
   parameter int unsigned       RAS_DEPTH    = 8,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
   input  logic                             Clock,
   input  logic                             Reset,
   input  logic                             Enable,
   input  logic [2:0]                       PCMode,
   input  logic [ADDR_W-1:0]                Target,
   input  logic [ADDR_W-1:0]                Offset,
   output logic [ADDR_W-1:0]                Instrucao,
   output logic                             StackFull,
   output logic                             StackEmpty,
   output logic                             Fault,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   StackCount
);

   pc_state_e         state_q;
   logic [ADDR_W-1:0] pc_q, pc_d, seq_pc, ret_pc;
   logic              fault_q;
   logic              run_en, push_req, pop_req;
   logic              overflow, underflow, ras_err, stack_fault;

   assign run_en      = (state_q == RUN) && Enable;
   assign push_req    = run_en && (PCMode == CALL);
   assign pop_req     = run_en && (PCMode == RET);
   assign overflow    = push_req & StackFull;
   assign underflow   = pop_req & StackEmpty;
   assign stack_fault = overflow | underflow | ras_err;

   assign seq_pc = pc_q + ADDR_W'(1);

   // Unused mode encodings fall through to sequential fetch.
   always_comb begin
      pc_d = seq_pc;
      case (PCMode)
         BRANCH:     pc_d = seq_pc + Offset;
         JUMP, CALL: pc_d = Target;
         RET:        pc_d = ret_pc;
         default:    pc_d = seq_pc;
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= BOOT;
         pc_q    <= RESET_VECTOR;
         fault_q <= 1'b0;
      end else begin
         unique case (state_q)
            BOOT: begin
               if (Enable) begin
                  state_q <= RUN;
               end
            end
            RUN: begin
               if (Enable) begin
                  if (stack_fault) begin
                     state_q <= FAULT;
                     fault_q <= 1'b1;
                  end else begin
                     pc_q <= pc_d;
                  end
               end
            end
            FAULT: begin
               fault_q <= 1'b1;
            end
            default: begin
               state_q <= BOOT;
            end
         endcase
      end
   end

   pc_ras #(
      .ADDR_W    (ADDR_W),
      .RAS_DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i       (Clock),
      .rst_i       (Reset),
      .push_i      (push_req),
      .pop_i       (pop_req),
      .push_data_i (seq_pc),
      .top_data_o  (ret_pc),
      .full_o      (StackFull),
      .empty_o     (StackEmpty),
      .count_o     (StackCount),
      .err_o       (ras_err)
   );

   assign Instrucao = pc_q;
   assign Fault     = fault_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: table-driven vectors through a scoreboard queue,
// plus hand-written boot, underflow, overflow and asynchronous-reset sequences.
module tb_pc_unit;
   import pc_pkg::*;

   localparam int unsigned AW    = 11;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned CW    = 4;

   localparam logic [2:0] M_SEQ = 3'd0;
   localparam logic [2:0] M_BR  = 3'd1;
   localparam logic [2:0] M_JMP = 3'd2;
   localparam logic [2:0] M_CAL = 3'd3;
   localparam logic [2:0] M_RET = 3'd4;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          Enable;
   logic [2:0]    PCMode;
   logic [AW-1:0] Target;
   logic [AW-1:0] Offset;
   logic [AW-1:0] Instrucao;
   logic          StackFull;
   logic          StackEmpty;
   logic          Fault;
   logic [CW-1:0] StackCount;

   typedef struct {
      logic [AW-1:0] pc;
      logic [CW-1:0] cnt;
      logic          fault;
   } exp_t;

   typedef struct {
      logic          en;
      logic [2:0]    mode;
      logic [AW-1:0] tgt;
      logic [AW-1:0] off;
      logic [AW-1:0] pc;
      int            cnt;
      logic          fault;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   pc_unit #(
      .ADDR_W       (AW),
      .RAS_DEPTH    (DEPTH),
      .RESET_VECTOR (11'd0)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Enable     (Enable),
      .PCMode     (PCMode),
      .Target     (Target),
      .Offset     (Offset),
      .Instrucao  (Instrucao),
      .StackFull  (StackFull),
      .StackEmpty (StackEmpty),
      .Fault      (Fault),
      .StackCount (StackCount)
   );

   always #5 Clock = ~Clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   task automatic check_all(input string tag, input exp_t e);
      check($sformatf("%s pc", tag), 32'(Instrucao), 32'(e.pc));
      check($sformatf("%s count", tag), 32'(StackCount), 32'(e.cnt));
      check($sformatf("%s full", tag), 32'(StackFull), 32'(e.cnt == CW'(DEPTH)));
      check($sformatf("%s empty", tag), 32'(StackEmpty), 32'(e.cnt == '0));
      check($sformatf("%s fault", tag), 32'(Fault), 32'(e.fault));
   endtask

   task automatic check_state(input string tag, input pc_state_e st);
      check($sformatf("%s state", tag), 32'(dut.state_q), 32'(st));
   endtask

   // Drive one cycle, queue its expectation, compare once the edge has produced output.
   task automatic step(input string tag, input logic en, input logic [2:0] mode,
                       input logic [AW-1:0] tgt, input logic [AW-1:0] off,
                       input logic [AW-1:0] epc, input int ecnt, input logic efault);
      exp_t e;
      Enable = en;
      PCMode = mode;
      Target = tgt;
      Offset = off;
      e.pc    = epc;
      e.cnt   = CW'(ecnt);
      e.fault = efault;
      sb_q.push_back(e);
      @(posedge Clock);
      #1;
      check_all(tag, sb_q.pop_front());
   endtask

   task automatic async_reset_check(input string tag);
      exp_t e;
      #2;
      Reset = 1'b1;
      #1;
      e.pc    = '0;
      e.cnt   = '0;
      e.fault = 1'b0;
      check_all(tag, e);
      check_state(tag, BOOT);
      #2;
      Reset = 1'b0;
   endtask

   function automatic vec_t mk(input logic en, input logic [2:0] mode, input logic [AW-1:0] tgt,
                               input logic [AW-1:0] off, input logic [AW-1:0] pc, input int cnt,
                               input logic fault);
      vec_t v;
      v.en = en; v.mode = mode; v.tgt = tgt; v.off = off;
      v.pc = pc; v.cnt = cnt; v.fault = fault;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t e0;
      Reset  = 1'b1;
      Enable = 1'b0;
      PCMode = M_SEQ;
      Target = '0;
      Offset = '0;
      #2;
      e0.pc = '0; e0.cnt = '0; e0.fault = 1'b0;
      check_all("reset", e0);
      check_state("reset", BOOT);
      @(posedge Clock);
      #3;
      Reset = 1'b0;

      // Boot: stall holds BOOT, first enabled edge keeps the reset vector
      step("boot_stall", 1'b0, M_SEQ, '0, '0, 11'd0, 0, 1'b0);
      check_state("boot_stall", BOOT);
      step("boot0", 1'b1, M_JMP, 11'd55, '0, 11'd0, 0, 1'b0);
      check_state("boot0", RUN);
      step("boot1", 1'b1, M_SEQ, '0, '0, 11'd1, 0, 1'b0);
      step("boot2", 1'b1, M_SEQ, '0, '0, 11'd2, 0, 1'b0);
      step("boot3", 1'b1, M_SEQ, '0, '0, 11'd3, 0, 1'b0);

      vecs.push_back(mk(1'b1, M_JMP, 11'd10,  '0,      11'd10,  0, 1'b0));
      vecs.push_back(mk(1'b1, M_BR,  '0,      11'h7FE, 11'd9,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_JMP, 11'h7FF, '0,      11'h7FF, 0, 1'b0));
      vecs.push_back(mk(1'b1, M_SEQ, '0,      '0,      11'd0,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_BR,  '0,      11'd5,   11'd6,   0, 1'b0));
      vecs.push_back(mk(1'b1, 3'd5,  11'd77,  11'd9,   11'd7,   0, 1'b0));
      vecs.push_back(mk(1'b1, 3'd6,  11'd77,  11'd9,   11'd8,   0, 1'b0));
      vecs.push_back(mk(1'b1, 3'd7,  11'd77,  11'd9,   11'd9,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_JMP, 11'd5,   '0,      11'd5,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_CAL, 11'd100, '0,      11'd100, 1, 1'b0));
      vecs.push_back(mk(1'b1, M_SEQ, '0,      '0,      11'd101, 1, 1'b0));
      vecs.push_back(mk(1'b1, M_SEQ, '0,      '0,      11'd102, 1, 1'b0));
      vecs.push_back(mk(1'b1, M_RET, '0,      '0,      11'd6,   0, 1'b0));
      vecs.push_back(mk(1'b0, M_CAL, 11'd300, '0,      11'd6,   0, 1'b0));
      vecs.push_back(mk(1'b0, M_CAL, 11'd300, '0,      11'd6,   0, 1'b0));
      vecs.push_back(mk(1'b0, M_CAL, 11'd300, '0,      11'd6,   0, 1'b0));
      vecs.push_back(mk(1'b0, M_RET, '0,      '0,      11'd6,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_BR,  '0,      11'd0,   11'd7,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_CAL, 11'd200, '0,      11'd200, 1, 1'b0));
      vecs.push_back(mk(1'b1, M_CAL, 11'd300, '0,      11'd300, 2, 1'b0));
      vecs.push_back(mk(1'b1, M_RET, '0,      '0,      11'd201, 1, 1'b0));
      vecs.push_back(mk(1'b1, M_RET, '0,      '0,      11'd8,   0, 1'b0));
      vecs.push_back(mk(1'b1, M_JMP, 11'h7FE, '0,      11'h7FE, 0, 1'b0));
      vecs.push_back(mk(1'b1, M_BR,  '0,      11'd2,   11'd1,   0, 1'b0));

      foreach (vecs[i]) begin
         step($sformatf("vec%0d", i), vecs[i].en, vecs[i].mode, vecs[i].tgt, vecs[i].off,
              vecs[i].pc, vecs[i].cnt, vecs[i].fault);
      end

      // Underflow: RET on an empty stack faults and freezes everything
      step("unf_ret", 1'b1, M_RET, '0, '0, 11'd1, 0, 1'b1);
      check_state("unf_ret", FAULT);
      step("unf_seq", 1'b1, M_SEQ, '0, '0, 11'd1, 0, 1'b1);
      step("unf_jmp", 1'b1, M_JMP, 11'd50, '0, 11'd1, 0, 1'b1);
      step("unf_call", 1'b1, M_CAL, 11'd50, '0, 11'd1, 0, 1'b1);
      step("unf_stall", 1'b0, M_SEQ, '0, '0, 11'd1, 0, 1'b1);

      async_reset_check("rst_unf");
      step("reboot0", 1'b1, M_SEQ, '0, '0, 11'd0, 0, 1'b0);
      step("reboot1", 1'b1, M_SEQ, '0, '0, 11'd1, 0, 1'b0);

      // Overflow: eight nested calls fill the stack, the ninth faults
      for (int i = 0; i < 8; i++) begin
         step($sformatf("call%0d", i), 1'b1, M_CAL, AW'(20 + i), '0, AW'(20 + i), i + 1, 1'b0);
      end
      step("ovf_call", 1'b1, M_CAL, 11'd99, '0, 11'd27, 8, 1'b1);
      check_state("ovf_call", FAULT);
      step("ovf_seq0", 1'b1, M_SEQ, '0, '0, 11'd27, 8, 1'b1);
      step("ovf_seq1", 1'b1, M_SEQ, '0, '0, 11'd27, 8, 1'b1);
      step("ovf_ret", 1'b1, M_RET, '0, '0, 11'd27, 8, 1'b1);

      async_reset_check("rst_ovf");
      step("boot_b0", 1'b1, M_SEQ, '0, '0, 11'd0, 0, 1'b0);
      step("boot_b1", 1'b1, M_SEQ, '0, '0, 11'd1, 0, 1'b0);
      step("discard_ret", 1'b1, M_RET, '0, '0, 11'd1, 0, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter ADDR_W, default 11, SHALL set the program-counter and target width in bits.
REQ-002 Parameter RAS_DEPTH, default 8, SHALL set the return-address-stack entry count; the legal range is 2..64.
REQ-003 Parameter RESET_VECTOR, default 0, SHALL set the address loaded on reset.
REQ-004 Port Clock, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port Enable, input, 1 bit: advance when 1, stall when 0.
REQ-007 Port PCMode, input, 3 bits: next-PC mode, one of SEQ=0, BRANCH=1, JUMP=2, CALL=3, RET=4.
REQ-008 Port Target, input, ADDR_W bits: the absolute address for JUMP and CALL.
REQ-009 Port Offset, input, ADDR_W bits: two's-complement displacement for BRANCH.
REQ-010 Port Instrucao, output, ADDR_W bits: the current PC, driven directly from a register.
REQ-011 Port StackFull, output, 1 bit: the stack holds RAS_DEPTH entries.
REQ-012 Port StackEmpty, output, 1 bit: the stack holds 0 entries.
REQ-013 Port Fault, output, 1 bit: sticky flag for a stack overflow or underflow.
REQ-014 Port StackCount, output, $clog2(RAS_DEPTH+1) bits: the current number of stack entries.

Function
REQ-015 The FSM SHALL have three states: BOOT, RUN and FAULT.
REQ-016 In BOOT, the first rising edge with Enable=1 SHALL keep Instrucao=RESET_VECTOR, move the FSM to RUN, and ignore PCMode.
REQ-017 In RUN with Enable=1, Instrucao SHALL update at the edge to a value chosen by PCMode:
- SEQ: PC+1.
- BRANCH: PC+1+Offset.
- JUMP: Target.
- CALL: Target, and push PC+1.
- RET: the popped top-of-stack.
REQ-018 All next-PC arithmetic SHALL be modulo 2^ADDR_W, so it wraps silently with no flag.
REQ-019 PCMode values 5, 6 and 7 SHALL behave as SEQ.
REQ-020 When Enable=0, PC, stack, count and FSM state SHALL all hold, and PCMode SHALL be ignored.
REQ-021 CALL with StackFull=1 SHALL leave the PC and stack unchanged, set Fault, and enter FAULT.
REQ-022 RET with StackEmpty=1 SHALL leave the PC unchanged, set Fault, and enter FAULT.
REQ-023 In FAULT, the PC, stack and Fault SHALL hold regardless of Enable and PCMode; only Reset SHALL exit FAULT.
REQ-024 A CALL that fills the final slot SHALL succeed and assert StackFull after that edge.
REQ-025 A RET that pops the last entry SHALL succeed and assert StackEmpty after that edge.
REQ-026 The stack SHALL be LIFO with one push or one pop per cycle, never both.
REQ-027 StackFull, StackEmpty and StackCount SHALL be registered-state-derived and consistent in the same cycle as the count.
REQ-028 Latency from a PCMode/Enable sample to the new Instrucao SHALL be exactly one edge, with no combinational path from inputs to Instrucao.

Reset
REQ-029 Reset=1 SHALL immediately, without waiting for Clock, drive:
- Instrucao=RESET_VECTOR.
- FSM=BOOT.
- StackCount=0, StackEmpty=1, StackFull=0.
- Fault=0.
REQ-030 Asserting Reset mid-operation, including in FAULT, SHALL discard all stack contents; after release the BOOT rule (REQ-016) SHALL apply again.
REQ-031 Stack storage entries SHALL need no reset; only the pointer and count are reset.

Structure
REQ-032 Shared package pc_pkg SHALL hold the PCMode encoding constants (SEQ, BRANCH, JUMP, CALL, RET) and the FSM state typedef (BOOT, RUN, FAULT).
REQ-033 The stack SHALL be a sub-module, pc_ras, parametrised by ADDR_W and RAS_DEPTH.
- Ports: push, pop, push data, top data, full, empty, count.
- pc_ras SHALL flag but ignore an illegal push or pop.
REQ-034 pc_unit SHALL contain the FSM, the next-PC mux/adder, and the overflow/underflow detection.

Verification
REQ-035 Boot: reset, release, Enable=1 for 4 edges with SEQ -> Instrucao sequence 0, 0, 1, 2, 3.
REQ-036 Branch and wrap:
- At PC=10, BRANCH with Offset=11'h7FE (-2) -> PC=9.
- At PC=11'h7FF, SEQ -> PC=0.
REQ-037 Call/return: from PC=5, CALL Target=100, then SEQ, SEQ, RET -> sequence 100, 101, 102, 6; StackCount goes 1, 1, 1, 0.
REQ-038 Overflow: 8 nested CALLs -> StackFull=1 and Fault=0; a 9th CALL -> Fault=1, PC held, state FAULT, and further SEQ cycles leave PC unchanged.
REQ-039 Underflow and stall:
- RET with StackEmpty=1 -> Fault=1 and PC held.
- Enable=0 for 3 edges during a CALL request -> no push and no PC change.
REQ-040 Asynchronous reset: assert Reset between edges while in FAULT with StackCount=8 -> Instrucao=RESET_VECTOR, StackCount=0 and Fault=0 before the next edge; the BOOT hold is observed after release.
